// File: rtl/idec_stage_if.sv
// rtl/idec_stage_if.sv - fetch-side and issue-side bundles of the decode stage
interface idec_stage_if #(
  parameter int ALU_OPC_WIDTH = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              pc;
  logic [31:0]              inst_word;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              A;
  logic [31:0]              B;
  logic [31:0]              C;
  logic [4:0]               A_reg;
  logic [4:0]               B_reg;
  logic                     B_imm;
  logic [4:0]               shamt;
  logic [ALU_OPC_WIDTH-1:0] alu_op;
  logic                     alu_inst;
  logic                     mem_inst;
  logic                     mem_load;
  logic                     jmp_inst;
  logic                     br_inst;
  logic                     illegal;
  logic [4:0]               dest_reg;
  logic                     dest_reg_valid;

  modport master (
    output in_valid, pc, inst_word, out_ready,
    input  in_ready, out_valid, out_pc, A, B, C, A_reg, B_reg, B_imm, shamt, alu_op,
           alu_inst, mem_inst, mem_load, jmp_inst, br_inst, illegal, dest_reg, dest_reg_valid
  );

  modport slave (
    input  in_valid, pc, inst_word, out_ready,
    output in_ready, out_valid, out_pc, A, B, C, A_reg, B_reg, B_imm, shamt, alu_op,
           alu_inst, mem_inst, mem_load, jmp_inst, br_inst, illegal, dest_reg, dest_reg_valid
  );
endinterface

// File: rtl/idec_stage.sv
// rtl/idec_stage.sv - registered decode stage with per-register RAW scoreboard
module idec_stage #(
  parameter int ALU_OPC_WIDTH = 12,
  parameter int SB_CNT_WIDTH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  idec_stage_if.slave bus,
  output logic [4:0]  rfile_rd_addr1,
  output logic [4:0]  rfile_rd_addr2,
  input  logic [31:0] rfile_rd_data1,
  input  logic [31:0] rfile_rd_data2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic        flush
);
  localparam logic [SB_CNT_WIDTH-1:0] SB_MAX = '1;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_sext;

  assign opcode   = bus.inst_word[31:26];
  assign rs       = bus.inst_word[25:21];
  assign rt       = bus.inst_word[20:16];
  assign rd       = bus.inst_word[15:11];
  assign funct    = bus.inst_word[5:0];
  assign imm      = bus.inst_word[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};

  assign rfile_rd_addr1 = rs;
  assign rfile_rd_addr2 = rt;

  logic [31:0] d_b, d_c;
  logic [4:0]  d_a_reg, d_b_reg, d_dest, d_shamt;
  logic [5:0]  d_funct;
  logic        d_b_imm, d_alu, d_mem, d_load, d_jmp, d_br, d_ill, d_has_dest, d_dest_ok;

  always_comb begin
    d_a_reg    = rs;
    d_b_reg    = 5'd0;
    d_dest     = rt;
    d_has_dest = 1'b1;
    d_b_imm    = 1'b1;
    d_b        = {16'h0, imm};
    d_c        = 32'h0;
    d_shamt    = 5'd0;
    d_funct    = 6'd0;
    d_alu      = 1'b0;
    d_mem      = 1'b0;
    d_load     = 1'b0;
    d_jmp      = 1'b0;
    d_br       = 1'b0;
    d_ill      = 1'b0;
    case (opcode)
      6'h00: begin
        d_b_reg = rt;
        d_b_imm = 1'b0;
        d_b     = rfile_rd_data2;
        d_dest  = rd;
        d_shamt = bus.inst_word[10:6];
        d_funct = funct;
        case (funct)
          6'h08:   begin d_jmp = 1'b1; d_has_dest = 1'b0; end
          6'h09:   d_jmp = 1'b1;
          default: d_alu = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b: begin d_b = imm_sext; d_alu = 1'b1; end
      6'h0c, 6'h0d, 6'h0e:        d_alu = 1'b1;
      6'h0f: begin d_b = {imm, 16'h0}; d_a_reg = 5'd0; d_alu = 1'b1; end
      6'h04, 6'h05: begin
        d_br = 1'b1; d_b_reg = rt; d_b = rfile_rd_data2; d_b_imm = 1'b0; d_has_dest = 1'b0;
      end
      6'h02: begin d_jmp = 1'b1; d_has_dest = 1'b0; d_a_reg = 5'd0; end
      6'h03: begin d_jmp = 1'b1; d_dest = 5'd31; d_a_reg = 5'd0; end
      6'h23: begin d_mem = 1'b1; d_load = 1'b1; d_b = imm_sext; end
      6'h2b: begin
        d_mem = 1'b1; d_b = imm_sext; d_b_reg = rt; d_c = rfile_rd_data2; d_has_dest = 1'b0;
      end
      default: begin d_ill = 1'b1; d_has_dest = 1'b0; d_a_reg = 5'd0; d_b_reg = 5'd0; end
    endcase
  end

  assign d_dest_ok = d_has_dest && (d_dest != 5'd0);

  // Pending-write counters; the held (not yet issued) bundle is covered by the dest compare below.
  logic [SB_CNT_WIDTH-1:0] sb_cnt [32];
  logic a_busy, b_busy, dest_sat, hazard, accept, issue, sb_inc, sb_dec;

  assign a_busy   = (d_a_reg != 5'd0) && ((sb_cnt[d_a_reg] != '0) ||
                    (bus.out_valid && bus.dest_reg_valid && bus.dest_reg == d_a_reg));
  assign b_busy   = (d_b_reg != 5'd0) && ((sb_cnt[d_b_reg] != '0) ||
                    (bus.out_valid && bus.dest_reg_valid && bus.dest_reg == d_b_reg));
  assign dest_sat = d_dest_ok && (sb_cnt[d_dest] == SB_MAX);
  assign hazard   = a_busy || b_busy || dest_sat;

  assign bus.in_ready = reset_n && !flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign issue        = bus.out_valid && bus.out_ready;
  assign sb_inc       = issue && bus.dest_reg_valid;
  assign sb_dec       = wb_valid && (wb_reg != 5'd0) && (sb_cnt[wb_reg] != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({sb_inc && (bus.dest_reg == 5'(i)), sb_dec && (wb_reg == 5'(i))})
          2'b10:   sb_cnt[i] <= sb_cnt[i] + 1'b1;
          2'b01:   sb_cnt[i] <= sb_cnt[i] - 1'b1;
          default: sb_cnt[i] <= sb_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_pc         <= 32'h0;
      bus.A              <= 32'h0;
      bus.B              <= 32'h0;
      bus.C              <= 32'h0;
      bus.A_reg          <= 5'd0;
      bus.B_reg          <= 5'd0;
      bus.B_imm          <= 1'b0;
      bus.shamt          <= 5'd0;
      bus.alu_op         <= '0;
      bus.alu_inst       <= 1'b0;
      bus.mem_inst       <= 1'b0;
      bus.mem_load       <= 1'b0;
      bus.jmp_inst       <= 1'b0;
      bus.br_inst        <= 1'b0;
      bus.illegal        <= 1'b0;
      bus.dest_reg       <= 5'd0;
      bus.dest_reg_valid <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid      <= 1'b1;
      bus.out_pc         <= bus.pc;
      bus.A              <= rfile_rd_data1;
      bus.B              <= d_b;
      bus.C              <= d_c;
      bus.A_reg          <= d_a_reg;
      bus.B_reg          <= d_b_reg;
      bus.B_imm          <= d_b_imm;
      bus.shamt          <= d_shamt;
      bus.alu_op         <= {opcode, d_funct};
      bus.alu_inst       <= d_alu;
      bus.mem_inst       <= d_mem;
      bus.mem_load       <= d_load;
      bus.jmp_inst       <= d_jmp;
      bus.br_inst        <= d_br;
      bus.illegal        <= d_ill;
      bus.dest_reg       <= d_dest;
      bus.dest_reg_valid <= d_dest_ok;
    end else if (issue) begin
      bus.out_valid <= 1'b0;
    end
  end

  // A writeback for a register with nothing outstanding means the core lost track of a write.
  wb_without_pending: assert property (@(posedge clock) disable iff (!reset_n)
    !(wb_valid && (wb_reg != 5'd0) && (sb_cnt[wb_reg] == '0)));
endmodule

// File: tb/tb_idec_stage.sv
// tb/tb_idec_stage.sv - randomized bench for idec_stage against a behavioural decode/scoreboard model
module tb_idec_stage;
  localparam int SBW    = 2;
  localparam int SB_MAX = (1 << SBW) - 1;

  typedef struct packed {
    logic [31:0] pc, a, b, c;
    logic [4:0]  a_reg, b_reg, shamt, dest;
    logic        b_imm, alu, mem, load, jmp, br, ill, dest_v;
    logic [11:0] op;
  } bundle_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rfile_rd_addr1, rfile_rd_addr2;
  logic [31:0] rfile_rd_data1 = '0, rfile_rd_data2 = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;

  idec_stage_if #(.ALU_OPC_WIDTH(12)) bus ();

  idec_stage #(.ALU_OPC_WIDTH(12), .SB_CNT_WIDTH(SBW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .rfile_rd_addr1(rfile_rd_addr1), .rfile_rd_addr2(rfile_rd_addr2),
    .rfile_rd_data1(rfile_rd_data1), .rfile_rd_data2(rfile_rd_data2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush)
  );

  always #5 clock = ~clock;

  int      total = 0, bad = 0;
  bundle_t held;
  bit      m_valid;
  int      cnt [32];
  logic [31:0] last_d2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bundle_t ref_decode(input logic [31:0] inst, pc, d1, d2);
    bundle_t r;
    logic [5:0]  op;
    logic [31:0] zx, sx;
    op = inst[31:26];
    zx = {16'h0, inst[15:0]};
    sx = {{16{inst[15]}}, inst[15:0]};
    r = '0;
    r.pc = pc; r.a = d1; r.a_reg = inst[25:21]; r.dest = inst[20:16];
    r.dest_v = 1'b1; r.b_imm = 1'b1; r.b = zx; r.op = {op, 6'h0};
    if (op == 6'h00) begin
      r.b_reg = inst[20:16]; r.b_imm = 1'b0; r.b = d2; r.dest = inst[15:11];
      r.shamt = inst[10:6]; r.op = {op, inst[5:0]};
      if (inst[5:0] == 6'h08) begin r.jmp = 1'b1; r.dest_v = 1'b0; end
      else if (inst[5:0] == 6'h09) r.jmp = 1'b1;
      else r.alu = 1'b1;
    end else if (op inside {[6'h08:6'h0b]}) begin r.b = sx; r.alu = 1'b1; end
    else if (op inside {[6'h0c:6'h0e]}) r.alu = 1'b1;
    else if (op == 6'h0f) begin r.b = {inst[15:0], 16'h0}; r.a_reg = 0; r.alu = 1'b1; end
    else if (op == 6'h04 || op == 6'h05) begin
      r.br = 1'b1; r.b_reg = inst[20:16]; r.b = d2; r.b_imm = 1'b0; r.dest_v = 1'b0;
    end
    else if (op == 6'h02) begin r.jmp = 1'b1; r.dest_v = 1'b0; r.a_reg = 0; end
    else if (op == 6'h03) begin r.jmp = 1'b1; r.dest = 5'd31; r.a_reg = 0; end
    else if (op == 6'h23) begin r.mem = 1'b1; r.load = 1'b1; r.b = sx; end
    else if (op == 6'h2b) begin
      r.mem = 1'b1; r.b = sx; r.b_reg = inst[20:16]; r.c = d2; r.dest_v = 1'b0;
    end
    else begin r.ill = 1'b1; r.dest_v = 1'b0; r.a_reg = 0; r.b_reg = 0; end
    if (r.dest == 5'd0) r.dest_v = 1'b0;
    return r;
  endfunction

  function automatic bit src_blocked(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return (cnt[r] != 0) || (m_valid && held.dest_v && held.dest == r);
  endfunction

  function automatic bit exp_in_ready();
    bundle_t d;
    d = ref_decode(bus.inst_word, bus.pc, rfile_rd_data1, rfile_rd_data2);
    if (flush || src_blocked(d.a_reg) || src_blocked(d.b_reg)) return 1'b0;
    if (d.dest_v && cnt[d.dest] == SB_MAX) return 1'b0;
    return !m_valid || bus.out_ready;
  endfunction

  function automatic logic [39:0] ctrl_of(input bundle_t b);
    return {b.a_reg, b.b_reg, b.shamt, b.dest, b.b_imm, b.alu, b.mem, b.load,
            b.jmp, b.br, b.ill, b.dest_v, b.op};
  endfunction

  function automatic logic [39:0] dut_ctrl();
    return {bus.A_reg, bus.B_reg, bus.shamt, bus.dest_reg, bus.B_imm, bus.alu_inst,
            bus.mem_inst, bus.mem_load, bus.jmp_inst, bus.br_inst, bus.illegal,
            bus.dest_reg_valid, bus.alu_op};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    held = '0;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
  endtask

  task automatic compare_and_step();
    bit rdy, acc, iss, dec_ok;
    rdy = exp_in_ready();
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("rd_addr", 64'({rfile_rd_addr1, rfile_rd_addr2}), 64'(bus.inst_word[25:16]));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_pc", 64'(bus.out_pc), 64'(held.pc));
      chk("opA", 64'(bus.A), 64'(held.a));
      chk("opB", 64'(bus.B), 64'(held.b));
      chk("opC", 64'(bus.C), 64'(held.c));
      chk("ctrl", 64'(dut_ctrl()), 64'(ctrl_of(held)));
    end
    acc    = bus.in_valid && rdy;
    iss    = m_valid && bus.out_ready;
    dec_ok = wb_valid && wb_reg != 0 && cnt[wb_reg] > 0;
    if (iss && held.dest_v) cnt[held.dest] = (cnt[held.dest] + 1) % (SB_MAX + 1);
    if (dec_ok) cnt[wb_reg] = cnt[wb_reg] - 1;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      held = ref_decode(bus.inst_word, bus.pc, rfile_rd_data1, rfile_rd_data2);
      m_valid = 1'b1;
    end else if (iss) m_valid = 1'b0;
  endtask

  // Called between negedge and the next posedge; returns at the following negedge.
  task automatic cycle(input bit v, input logic [31:0] inst, input bit ordy, input bit fl,
                       input bit wv, input logic [4:0] wr);
    bus.in_valid = v; bus.inst_word = inst; bus.pc = $urandom; bus.out_ready = ordy;
    flush = fl; wb_valid = wv; wb_reg = wr;
    rfile_rd_data1 = $urandom; rfile_rd_data2 = $urandom; last_d2 = rfile_rd_data2;
    #1;
    compare_and_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pick_wb(output bit wv, output logic [4:0] wr);
    int cands[$];
    for (int i = 1; i < 32; i++) if (cnt[i] > 0) cands.push_back(i);
    wv = 1'b0; wr = 5'd0;
    if (cands.size() > 0) begin
      wv = 1'b1;
      wr = 5'(cands[$urandom_range(0, cands.size() - 1)]);
    end
  endtask

  task automatic drain();
    bit wv; logic [4:0] wr; int pend;
    for (int k = 0; k < 200; k++) begin
      pend = 0;
      for (int i = 0; i < 32; i++) pend += cnt[i];
      if (!m_valid && pend == 0) break;
      pick_wb(wv, wr);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, wv, wr);
    end
    pend = 0;
    for (int i = 0; i < 32; i++) pend += cnt[i];
    chk("drain_done", 64'(pend + int'(m_valid)), 64'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [18];
    logic [5:0] fns [9];
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h2b, 6'h3f, 6'h11};
    fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08, 6'h09};
    op = ops[$urandom_range(0, 17)];
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    if (op == 6'h00) return {op, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 8)]};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    bit wv; logic [4:0] wr;
    model_reset();
    bus.in_valid = 1'b1; bus.inst_word = 32'h20010005; bus.pc = '0; bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_alu_op_dest", 64'({bus.alu_op, bus.dest_reg, bus.B}), 64'd0);
    @(posedge clock); @(posedge clock); @(negedge clock);
    reset_n = 1'b1;

    cycle(1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_B", 64'(bus.B), 64'd5);
    chk("addi_imm_dest", 64'({bus.B_imm, bus.dest_reg, bus.dest_reg_valid}), 64'({1'b1, 5'd1, 1'b1}));
    chk("addi_alu_op", 64'(bus.alu_op), 64'h200);

    cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("raw_stall", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b1, 5'd1);
    chk("raw_release", 64'(bus.in_ready), 64'd1);
    cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("add_dest", 64'({bus.out_valid, bus.dest_reg, bus.B_reg}), 64'({1'b1, 5'd3, 5'd2}));

    cycle(1'b1, 32'h2402FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("addiu_B", 64'(bus.B), 64'hFFFFFFFF);
    cycle(1'b1, 32'h3402FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("ori_B", 64'(bus.B), 64'h0000FFFF);

    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h20040001, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_B", 64'({bus.out_valid, bus.B}), 64'({1'b1, 32'h0000FFFF}));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    drain();

    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h20050001, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, 32'h20050001, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("sat_stall", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 32'h20050001, 1'b1, 1'b0, 1'b1, 5'd5);
    chk("sat_release", 64'(bus.in_ready), 64'd1);
    cycle(1'b1, 32'h20050001, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("sat_accept", 64'(bus.out_valid), 64'd1);
    drain();

    cycle(1'b1, 32'hFC221800, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("illegal", 64'({bus.illegal, bus.dest_reg_valid}), 64'({1'b1, 1'b0}));
    cycle(1'b1, 32'hAC430008, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("sw_C", 64'(bus.C), 64'(last_d2));
    chk("sw_flags", 64'({bus.mem_inst, bus.mem_load, bus.dest_reg_valid, bus.B_reg, bus.B}),
        64'({1'b1, 1'b0, 1'b0, 5'd3, 32'h8}));
    drain();

    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < (pass == 0 ? 1500 : 400); k++) begin
        wv = 1'b0; wr = 5'd0;
        if ($urandom_range(0, 9) < 4) pick_wb(wv, wr);
        cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, wv, wr);
      end
      if (pass == 0) begin
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.in_ready), 64'd0);
        model_reset();
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
